// File: rtl/d_cache_writeback_buffer_pkg.sv
// Shared constants and types for the data-cache writeback buffer and its AXI write channels.
package d_cache_writeback_buffer_pkg;
  localparam int ADDR_WIDTH    = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int AXI_ID_WIDTH  = 4;
  localparam int AXI_LEN_WIDTH = 8;

  localparam logic [AXI_ID_WIDTH-1:0] WB_AXI_ID = '0;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_ADDR,
    WB_DATA,
    WB_RESP
  } WbState;
endpackage

// File: rtl/d_cache_writeback_buffer_if.sv
// AXI write-side channel bundles (AW, W, B) used between the writeback buffer and memory.
interface axi_write_address;
  import d_cache_writeback_buffer_pkg::*;
  logic [AXI_ID_WIDTH-1:0]  awid;
  logic [ADDR_WIDTH-1:0]    awaddr;
  logic [AXI_LEN_WIDTH-1:0] awlen;
  logic                     awvalid;
  logic                     awready;

  modport master (output awid, awaddr, awlen, awvalid, input awready);
  modport slave  (input awid, awaddr, awlen, awvalid, output awready);
endinterface

interface axi_write_data;
  import d_cache_writeback_buffer_pkg::*;
  logic [AXI_ID_WIDTH-1:0] wid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  modport master (output wid, wdata, wlast, wvalid, input wready);
  modport slave  (input wid, wdata, wlast, wvalid, output wready);
endinterface

interface axi_write_response;
  logic bvalid;
  logic bready;

  modport master (input bvalid, output bready);
  modport slave  (output bvalid, input bready);
endinterface

// File: rtl/d_cache_writeback_buffer_fifo.sv
// Circular line store for the writeback buffer: pointers, occupancy count and per-entry
// line-address compare for the refill lookup.
module writeback_line_fifo
  import d_cache_writeback_buffer_pkg::*;
#(
  parameter int LINE_SIZE = 4,
  parameter int ENTRIES   = 2,
  localparam int LINE_W   = LINE_SIZE * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [ADDR_WIDTH-1:0] push_addr_i,
  input  logic [LINE_W-1:0]     push_data_i,
  input  logic                  pop_i,
  input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
  output logic                  lookup_hit_o,
  output logic [ADDR_WIDTH-1:0] head_addr_o,
  output logic [LINE_W-1:0]     head_data_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int PTR_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CNT_W   = $clog2(ENTRIES + 1);
  localparam int TAG_LSB = $clog2(LINE_SIZE) + 2;
  localparam logic [ADDR_WIDTH-1:0] TAG_MASK = ~((ADDR_WIDTH'(1) << TAG_LSB) - ADDR_WIDTH'(1));

  logic [ADDR_WIDTH-1:0] addr_q [ENTRIES];
  logic [LINE_W-1:0]     data_q [ENTRIES];
  logic [ENTRIES-1:0]    occ_q, occ_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ENTRIES - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pop clears before push sets, so a slot reused on the same edge stays occupied.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    occ_d    = occ_q;
    if (pop_i) begin
      occ_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = ptr_inc(rd_ptr_q);
    end
    if (push_i) begin
      occ_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_comb begin
    lookup_hit_o = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (occ_q[i] && ((addr_q[i] & TAG_MASK) == (lookup_addr_i & TAG_MASK))) begin
        lookup_hit_o = 1'b1;
      end
    end
  end

  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign full_o      = (count_q == CNT_W'(ENTRIES));
  assign empty_o     = (count_q == '0);
endmodule

// File: rtl/d_cache_writeback_buffer.sv
// Writeback buffer between d_cache and memory: accepts evicted lines in one cycle and drains
// them one AXI write burst at a time.
module d_cache_writeback_buffer
  import d_cache_writeback_buffer_pkg::*;
#(
  parameter int LINE_SIZE = 4,
  parameter int ENTRIES   = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push_valid,
  output logic                            push_ready,
  input  logic [ADDR_WIDTH-1:0]           push_addr,
  input  logic [LINE_SIZE*DATA_WIDTH-1:0] push_data,
  input  logic [ADDR_WIDTH-1:0]           lookup_addr,
  output logic                            lookup_hit,
  output logic                            empty,
  axi_write_address.master                mem_write_address,
  axi_write_data.master                   mem_write_data,
  axi_write_response.master               mem_write_response
);
  localparam int BEAT_W = $clog2(LINE_SIZE);

  WbState                          state_q, state_d;
  logic [BEAT_W-1:0]               beat_q, beat_d;
  logic                            push, pop, fifo_full, fifo_empty;
  logic                            aw_valid, w_valid, w_last;
  logic [ADDR_WIDTH-1:0]           head_addr;
  logic [LINE_SIZE*DATA_WIDTH-1:0] head_data;

  assign push_ready = ~fifo_full;
  assign push       = push_valid & push_ready;

  writeback_line_fifo #(
    .LINE_SIZE (LINE_SIZE),
    .ENTRIES   (ENTRIES)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .push_i        (push),
    .push_addr_i   (push_addr),
    .push_data_i   (push_data),
    .pop_i         (pop),
    .lookup_addr_i (lookup_addr),
    .lookup_hit_o  (lookup_hit),
    .head_addr_o   (head_addr),
    .head_data_o   (head_data),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty)
  );

  // The head entry is only released on the B response, so it stays visible to lookup.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    w_last   = 1'b0;
    pop      = 1'b0;
    case (state_q)
      WB_IDLE: if (!fifo_empty) state_d = WB_ADDR;
      WB_ADDR: begin
        aw_valid = 1'b1;
        if (mem_write_address.awready) begin
          state_d = WB_DATA;
          beat_d  = '0;
        end
      end
      WB_DATA: begin
        w_valid = 1'b1;
        w_last  = (beat_q == BEAT_W'(LINE_SIZE - 1));
        if (mem_write_data.wready) begin
          if (w_last) state_d = WB_RESP;
          else        beat_d  = beat_q + 1'b1;
        end
      end
      WB_RESP: begin
        if (mem_write_response.bvalid) begin
          pop     = 1'b1;
          state_d = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WB_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // AWLEN carries the beat count itself, matching the in-house memory model.
  assign mem_write_address.awid    = WB_AXI_ID;
  assign mem_write_address.awaddr  = head_addr;
  assign mem_write_address.awlen   = AXI_LEN_WIDTH'(LINE_SIZE);
  assign mem_write_address.awvalid = aw_valid;

  assign mem_write_data.wid    = WB_AXI_ID;
  assign mem_write_data.wdata  = head_data[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH];
  assign mem_write_data.wlast  = w_last;
  assign mem_write_data.wvalid = w_valid;

  assign mem_write_response.bready = 1'b1;

  assign empty = fifo_empty & (state_q == WB_IDLE);
endmodule

// File: tb/tb_d_cache_writeback_buffer.sv
// Directed bench for d_cache_writeback_buffer with LINE_SIZE=4, ENTRIES=2.
module tb_d_cache_writeback_buffer;
  import d_cache_writeback_buffer_pkg::*;
  localparam int LS = 4;
  localparam int EN = 2;

  logic          clk, rst, push_valid, push_ready, lookup_hit, empty;
  logic [31:0]   push_addr, lookup_addr;
  logic [LS*32-1:0] push_data;
  int            n_tests, n_fail, b_delay;
  logic [31:0]   aw_q[$];
  logic [31:0]   w_q[$];

  axi_write_address  aw_if();
  axi_write_data     w_if();
  axi_write_response b_if();

  d_cache_writeback_buffer #(.LINE_SIZE(LS), .ENTRIES(EN)) dut (
    .clk                (clk),
    .rst                (rst),
    .push_valid         (push_valid),
    .push_ready         (push_ready),
    .push_addr          (push_addr),
    .push_data          (push_data),
    .lookup_addr        (lookup_addr),
    .lookup_hit         (lookup_hit),
    .empty              (empty),
    .mem_write_address  (aw_if),
    .mem_write_data     (w_if),
    .mem_write_response (b_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // Record AW and W handshakes that will complete at the coming edge.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        if (aw_if.awvalid && aw_if.awready) aw_q.push_back(aw_if.awaddr);
        if (w_if.wvalid && w_if.wready) w_q.push_back(w_if.wdata);
      end
    end
  end

  // Memory B responder: one-cycle BVALID, b_delay cycles after the last W beat.
  initial begin
    b_if.bvalid = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (!rst && w_if.wvalid && w_if.wready && w_if.wlast) begin
        @(posedge clk);
        repeat (b_delay) @(posedge clk);
        #1 b_if.bvalid = 1'b1;
        @(posedge clk);
        #1 b_if.bvalid = 1'b0;
      end
    end
  end

  function automatic logic [LS*32-1:0] mk_line(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  task automatic push_line(input logic [31:0] a, input logic [LS*32-1:0] d, output bit ok);
    push_valid = 1'b1;
    push_addr  = a;
    push_data  = d;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (push_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    push_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (empty) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_tests++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_push_ready: got %b expected 1", push_ready); end
    n_tests++; if (aw_if.awvalid !== 1'b0) begin n_fail++; $display("FAIL reset_awvalid: got %b expected 0", aw_if.awvalid); end
    n_tests++; if (w_if.wvalid !== 1'b0) begin n_fail++; $display("FAIL reset_wvalid: got %b expected 0", w_if.wvalid); end
    n_tests++; if (w_if.wlast !== 1'b0) begin n_fail++; $display("FAIL reset_wlast: got %b expected 0", w_if.wlast); end
    n_tests++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL reset_lookup_hit: got %b expected 0", lookup_hit); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_tests++; if (b_if.bready !== 1'b1) begin n_fail++; $display("FAIL reset_bready: got %b expected 1", b_if.bready); end
    @(negedge clk);
  endtask

  task automatic test_single();
    aw_q.delete(); w_q.delete();
    b_delay = 0; aw_if.awready = 1'b1; w_if.wready = 1'b1;
    lookup_addr = 32'h400;
    push_valid = 1'b1; push_addr = 32'h400; push_data = mk_line(32'd1);
    n_tests++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL single_hit_before_push: got %b expected 0", lookup_hit); end
    @(negedge clk);
    push_valid = 1'b0;
    n_tests++; if (aw_if.awvalid !== 1'b0) begin n_fail++; $display("FAIL single_aw_early: got %b expected 0", aw_if.awvalid); end
    n_tests++; if (lookup_hit !== 1'b1) begin n_fail++; $display("FAIL single_hit_after_push: got %b expected 1", lookup_hit); end
    n_tests++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_empty_busy: got %b expected 0", empty); end
    @(negedge clk);
    n_tests++; if (aw_if.awvalid !== 1'b1) begin n_fail++; $display("FAIL single_awvalid: got %b expected 1", aw_if.awvalid); end
    n_tests++; if (aw_if.awaddr !== 32'h400) begin n_fail++; $display("FAIL single_awaddr: got %h expected 00000400", aw_if.awaddr); end
    n_tests++; if (aw_if.awlen !== 8'd4) begin n_fail++; $display("FAIL single_awlen: got %0d expected 4", aw_if.awlen); end
    n_tests++; if (aw_if.awid !== 4'd0) begin n_fail++; $display("FAIL single_awid: got %0d expected 0", aw_if.awid); end
    @(negedge clk);
    n_tests++; if (aw_if.awvalid !== 1'b0) begin n_fail++; $display("FAIL single_aw_drop: got %b expected 0", aw_if.awvalid); end
    for (int beat = 0; beat < LS; beat++) begin
      n_tests++; if (w_if.wvalid !== 1'b1) begin n_fail++; $display("FAIL single_wvalid beat %0d: got %b expected 1", beat, w_if.wvalid); end
      n_tests++; if (w_if.wdata !== 32'(beat + 1)) begin n_fail++; $display("FAIL single_wdata beat %0d: got %h expected %h", beat, w_if.wdata, beat + 1); end
      n_tests++; if (w_if.wlast !== (beat == LS - 1)) begin n_fail++; $display("FAIL single_wlast beat %0d: got %b expected %b", beat, w_if.wlast, beat == LS - 1); end
      @(negedge clk);
    end
    n_tests++; if (w_if.wvalid !== 1'b0) begin n_fail++; $display("FAIL single_resp_wvalid: got %b expected 0", w_if.wvalid); end
    n_tests++; if (lookup_hit !== 1'b1) begin n_fail++; $display("FAIL single_resp_hit: got %b expected 1", lookup_hit); end
    n_tests++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_resp_empty: got %b expected 0", empty); end
    @(negedge clk);
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_done_empty: got %b expected 1", empty); end
    n_tests++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL single_done_hit: got %b expected 0", lookup_hit); end
    n_tests++; if (w_q.size() !== LS) begin n_fail++; $display("FAIL single_beats: got %0d expected %0d", w_q.size(), LS); end
  endtask

  task automatic test_back_to_back();
    int waits;
    bit ok;
    aw_q.delete(); w_q.delete();
    b_delay = 0;
    push_valid = 1'b1; push_addr = 32'h1000; push_data = mk_line(32'hA0);
    @(negedge clk);
    n_tests++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_one: got %b expected 1", push_ready); end
    push_addr = 32'h1010; push_data = mk_line(32'hB0);
    @(negedge clk);
    n_tests++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full: got %b expected 0", push_ready); end
    push_addr = 32'h1020; push_data = mk_line(32'hC0);
    waits = 0;
    for (int i = 0; i < 50; i++) begin
      if (push_ready) break;
      @(negedge clk);
      waits++;
    end
    n_tests++; if (waits !== 6) begin n_fail++; $display("FAIL b2b_third_accept: got %0d cycles expected 6", waits); end
    @(negedge clk);
    push_valid = 1'b0;
    n_tests++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_refull: got %b expected 0", push_ready); end
    wait_idle(ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got busy expected empty"); end
    n_tests++; if (aw_q.size() !== 3) begin n_fail++; $display("FAIL b2b_aw_count: got %0d expected 3", aw_q.size()); end
    for (int k = 0; k < 3 && k < aw_q.size(); k++) begin
      n_tests++; if (aw_q[k] !== 32'h1000 + 32'(k * 16)) begin n_fail++; $display("FAIL b2b_awaddr %0d: got %h expected %h", k, aw_q[k], 32'h1000 + k * 16); end
    end
    n_tests++; if (w_q.size() !== 12) begin n_fail++; $display("FAIL b2b_w_count: got %0d expected 12", w_q.size()); end
    if (w_q.size() == 12) begin
      n_tests++; if (w_q[0] !== 32'hA0) begin n_fail++; $display("FAIL b2b_wdata_a: got %h expected a0", w_q[0]); end
      n_tests++; if (w_q[7] !== 32'hB3) begin n_fail++; $display("FAIL b2b_wdata_b: got %h expected b3", w_q[7]); end
      n_tests++; if (w_q[8] !== 32'hC0) begin n_fail++; $display("FAIL b2b_wdata_c: got %h expected c0", w_q[8]); end
    end
  endtask

  task automatic test_wready_stall();
    int beat, k;
    bit ok;
    aw_q.delete(); w_q.delete();
    b_delay = 0; w_if.wready = 1'b0;
    push_line(32'h2000, mk_line(32'hD0), ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_push: got rejected expected accepted"); end
    for (int i = 0; i < 20 && !w_if.wvalid; i++) @(negedge clk);
    beat = 0; k = 0;
    while (w_if.wvalid && k < 40) begin
      n_tests++; if (w_if.wdata !== 32'hD0 + 32'(beat)) begin n_fail++; $display("FAIL stall_wdata k=%0d: got %h expected %h", k, w_if.wdata, 32'hD0 + beat); end
      n_tests++; if (w_if.wlast !== (beat == LS - 1)) begin n_fail++; $display("FAIL stall_wlast k=%0d: got %b expected %b", k, w_if.wlast, beat == LS - 1); end
      w_if.wready = (k % 3 == 0);
      @(negedge clk);
      if (w_if.wready) beat++;
      k++;
    end
    w_if.wready = 1'b1;
    n_tests++; if (beat !== LS) begin n_fail++; $display("FAIL stall_beats: got %0d expected %0d", beat, LS); end
    n_tests++; if (k !== 10) begin n_fail++; $display("FAIL stall_cycles: got %0d expected 10", k); end
    wait_idle(ok);
    n_tests++; if (w_q.size() !== LS) begin n_fail++; $display("FAIL stall_wq: got %0d expected %0d", w_q.size(), LS); end
  endtask

  task automatic test_lookup();
    int resp;
    bit popped, ok;
    aw_q.delete(); w_q.delete();
    b_delay = 10;
    lookup_addr = 32'h800; #1;
    n_tests++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL lookup_pre: got %b expected 0", lookup_hit); end
    push_line(32'h800, mk_line(32'h80), ok);
    popped = 1'b0; resp = 0;
    for (int i = 0; i < 80; i++) begin
      if (w_q.size() == LS && !w_if.wvalid) resp++;
      lookup_addr = 32'h810; #1;
      n_tests++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL lookup_nomatch i=%0d: got %b expected 0", i, lookup_hit); end
      lookup_addr = 32'h80C; #1;
      n_tests++; if (lookup_hit !== 1'b1) begin n_fail++; $display("FAIL lookup_offset i=%0d: got %b expected 1", i, lookup_hit); end
      lookup_addr = 32'h800; #1;
      n_tests++; if (lookup_hit !== 1'b1) begin n_fail++; $display("FAIL lookup_hit i=%0d: got %b expected 1", i, lookup_hit); end
      if (b_if.bvalid) begin
        popped = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    n_tests++; if (popped !== 1'b1) begin n_fail++; $display("FAIL lookup_bresp: got none expected one"); end
    n_tests++; if (resp !== 11) begin n_fail++; $display("FAIL lookup_resp_cycles: got %0d expected 11", resp); end
    n_tests++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL lookup_after_b: got %b expected 0", lookup_hit); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL lookup_empty: got %b expected 1", empty); end
    b_delay = 0;
  endtask

  task automatic test_simul_push_pop();
    bit ok;
    aw_q.delete(); w_q.delete();
    b_delay = 2;
    push_line(32'h4000, mk_line(32'h40), ok);
    for (int i = 0; i < 60 && !b_if.bvalid; i++) @(negedge clk);
    n_tests++; if (b_if.bvalid !== 1'b1) begin n_fail++; $display("FAIL simul_bvalid: got %b expected 1", b_if.bvalid); end
    push_valid = 1'b1; push_addr = 32'h4010; push_data = mk_line(32'h50);
    @(negedge clk);
    push_valid = 1'b0;
    n_tests++; if (empty !== 1'b0) begin n_fail++; $display("FAIL simul_empty: got %b expected 0", empty); end
    n_tests++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL simul_ready: got %b expected 1", push_ready); end
    lookup_addr = 32'h4010; #1;
    n_tests++; if (lookup_hit !== 1'b1) begin n_fail++; $display("FAIL simul_hit_new: got %b expected 1", lookup_hit); end
    lookup_addr = 32'h4000; #1;
    n_tests++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL simul_hit_old: got %b expected 0", lookup_hit); end
    @(negedge clk);
    wait_idle(ok);
    n_tests++; if (aw_q.size() !== 2 || aw_q[1] !== 32'h4010) begin n_fail++; $display("FAIL simul_order: got %0d bursts expected 2 ending at 00004010", aw_q.size()); end
    n_tests++; if (w_q.size() !== 8 || w_q[4] !== 32'h50) begin n_fail++; $display("FAIL simul_wdata: got %0d beats expected 8 with beat4=50", w_q.size()); end
    b_delay = 0;
  endtask

  task automatic test_fifo_order();
    bit ok;
    aw_q.delete(); w_q.delete();
    b_delay = 1;
    for (int i = 0; i < 8; i++) begin
      push_line(32'h5000 + 32'(i * 64), mk_line(32'(256 * (i + 1))), ok);
      n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL order_push %0d: got rejected expected accepted", i); end
    end
    wait_idle(ok);
    n_tests++; if (aw_q.size() !== 8) begin n_fail++; $display("FAIL order_aw_count: got %0d expected 8", aw_q.size()); end
    n_tests++; if (w_q.size() !== 32) begin n_fail++; $display("FAIL order_w_count: got %0d expected 32", w_q.size()); end
    for (int i = 0; i < 8 && i < aw_q.size(); i++) begin
      n_tests++; if (aw_q[i] !== 32'h5000 + 32'(i * 64)) begin n_fail++; $display("FAIL order_awaddr %0d: got %h expected %h", i, aw_q[i], 32'h5000 + i * 64); end
      for (int j = 0; j < LS && (i * LS + j) < w_q.size(); j++) begin
        n_tests++; if (w_q[i*LS+j] !== 32'(256 * (i + 1) + j)) begin n_fail++; $display("FAIL order_wdata %0d.%0d: got %h expected %h", i, j, w_q[i*LS+j], 256 * (i + 1) + j); end
      end
    end
    b_delay = 0;
  endtask

  task automatic test_reset_mid_burst();
    int n_aw;
    bit ok;
    aw_q.delete(); w_q.delete();
    b_delay = 0;
    push_line(32'h6000, mk_line(32'h60), ok);
    for (int i = 0; i < 30 && w_q.size() < 2; i++) @(negedge clk);
    n_tests++; if (w_if.wdata !== 32'h62) begin n_fail++; $display("FAIL mid_beat2: got %h expected 62", w_if.wdata); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lookup_addr = 32'h6000; #1;
    n_tests++; if (aw_if.awvalid !== 1'b0) begin n_fail++; $display("FAIL mid_awvalid: got %b expected 0", aw_if.awvalid); end
    n_tests++; if (w_if.wvalid !== 1'b0) begin n_fail++; $display("FAIL mid_wvalid: got %b expected 0", w_if.wvalid); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty: got %b expected 1", empty); end
    n_tests++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL mid_push_ready: got %b expected 1", push_ready); end
    n_tests++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL mid_lookup: got %b expected 0", lookup_hit); end
    n_aw = aw_q.size();
    repeat (5) @(negedge clk);
    n_tests++; if (aw_q.size() !== n_aw || empty !== 1'b1) begin n_fail++; $display("FAIL mid_stays_idle: got %0d bursts empty=%b expected %0d bursts empty=1", aw_q.size(), empty, n_aw); end
  endtask

  initial begin
    rst = 1'b1; push_valid = 1'b0; push_addr = '0; push_data = '0; lookup_addr = '0;
    aw_if.awready = 1'b0; w_if.wready = 1'b0;
    b_delay = 0; n_tests = 0; n_fail = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_wready_stall();
    test_lookup();
    test_simul_push_pop();
    test_fifo_order();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
